dmem_access_ctrl: RTL and testbench

Sequencing controller between the MEM pipeline stage and the word-wide data memory. Accepts one load/store request at a time and drives the memory's word-aligned address, byte enables and data lanes. Merges and extends load data, and splits accesses that cross a word boundary into two aligned beats. While busy it raises a stall to the hazard logic, so the pipeline sees a variable-latency data port.

---
 rtl/dmem_access_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for a word-wide data memory with lane alignment and load extension.
// Define DMEM_SPLIT_EN to split word-crossing accesses into two aligned beats; otherwise they raise misalign_err.
module dmem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
`ifdef DMEM_SPLIT_EN
        BEAT1 = 3'd2,
`endif
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_mask = 4'b0001;
            SIZE_HALF: size_mask = 4'b0011;
            default:   size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] k);
        case (k)
            2'd0:    lane_align = data;
            2'd1:    lane_align = {data[23:0], data[31:24]};
            2'd2:    lane_align = {data[15:0], data[31:16]};
            default: lane_align = {data[7:0],  data[31:8]};
        endcase
    endfunction

    state_t             state;
    logic               r_we;
    logic               r_unsigned;
    logic               r_split;
    logic [1:0]         r_size;
    logic [1:0]         r_k;
    logic [MEM_LAT-1:0] ret_pipe;
    logic [2:0]         outstanding;
`ifdef DMEM_SPLIT_EN
    logic [3:0]         r_be_hi;
    logic [31:0]        beat_lo;
`endif

    logic        capture;
    logic [7:0]  acc_lanes;
    logic        acc_split;
    logic [31:0] load_raw;
    logic [31:0] load_ext;

    // Lanes 7:4 of the shifted mask are the bytes that spill into the next word.
    assign acc_lanes = {4'b0000, size_mask(req_size)} << req_addr[1:0];
    assign acc_split = |acc_lanes[7:4];
    assign capture   = ret_pipe[MEM_LAT-1];

    // NOTE: load_ext gets a value on every path before the case, so no latch is inferred.
    always_comb begin
`ifdef DMEM_SPLIT_EN
        // Only consulted on the final return: beat1 is on mem_rdata, beat0 already sits in beat_lo.
        load_raw = r_split ? 32'({mem_rdata, beat_lo} >> {r_k, 3'b000})
                           : mem_rdata >> {r_k, 3'b000};
`else
        load_raw = mem_rdata >> {r_k, 3'b000};
`endif
        load_ext = load_raw;
        case (r_size)
            SIZE_BYTE: load_ext = r_unsigned ? {24'd0, load_raw[7:0]}
                                             : {{24{load_raw[7]}}, load_raw[7:0]};
            SIZE_HALF: load_ext = r_unsigned ? {16'd0, load_raw[15:0]}
                                             : {{16{load_raw[15]}}, load_raw[15:0]};
            default:   load_ext = load_raw;
        endcase
    end

    // NOTE: all state uses non-blocking assignments; the pulse defaults below are overridden by later NBAs in the case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            stall        <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            misalign_err <= 1'b0;
            mem_addr     <= 32'd0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_split      <= 1'b0;
            r_size       <= 2'd0;
            r_k          <= 2'd0;
            ret_pipe     <= '0;
            outstanding  <= 3'd0;
`ifdef DMEM_SPLIT_EN
            r_be_hi      <= 4'd0;
            beat_lo      <= 32'd0;
`endif
        end else begin
            resp_valid   <= 1'b0;
            misalign_err <= 1'b0;
            ret_pipe     <= MEM_LAT'({ret_pipe, mem_re});
            outstanding  <= outstanding + {2'b00, mem_re} - {2'b00, capture};
`ifdef DMEM_SPLIT_EN
            if (capture) beat_lo <= mem_rdata;
`endif
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_unsigned <= req_unsigned;
                        r_size     <= req_size;
                        r_k        <= req_addr[1:0];
                        r_split    <= acc_split;
                        req_ready  <= 1'b0;
                        stall      <= 1'b1;
                        state      <= BEAT0;
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        mem_wdata  <= lane_align(req_wdata, req_addr[1:0]);
`ifdef DMEM_SPLIT_EN
                        r_be_hi    <= acc_lanes[7:4];
                        mem_re     <= !req_we;
                        mem_we     <= req_we;
                        mem_be     <= acc_lanes[3:0];
`else
                        mem_re       <= !req_we && !acc_split;
                        mem_we       <= req_we && !acc_split;
                        mem_be       <= acc_split ? 4'd0 : acc_lanes[3:0];
                        misalign_err <= acc_split;
`endif
                    end
                end
                BEAT0: begin
`ifdef DMEM_SPLIT_EN
                    if (r_split) begin
                        state    <= BEAT1;
                        mem_addr <= {mem_addr[31:2] + 30'd1, 2'b00};
                        mem_be   <= r_be_hi;
                    end else
`endif
                    begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        mem_be <= 4'd0;
                        if (r_we || r_split) begin
                            state     <= IDLE;
                            req_ready <= 1'b1;
                            stall     <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
`ifdef DMEM_SPLIT_EN
                BEAT1: begin
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    mem_be <= 4'd0;
                    if (r_we) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        stall     <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
`endif
                WAIT: begin
                    if (capture && outstanding == 3'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    stall     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized bench for dmem_access_ctrl against a byte-addressed reference memory.
// Expectations follow MEM_LAT and whether DMEM_SPLIT_EN is defined for the build.
module tb_dmem_access_ctrl;

    parameter int MEM_LAT = 1;
`ifdef DMEM_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_access_ctrl #(.MEM_LAT(MEM_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_ready    (req_ready),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .misalign_err (misalign_err),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Word memory driven only by the DUT's strobes; returns read data MEM_LAT cycles after mem_re.
    logic [31:0] mem_w [bit [29:0]];
    bit          hist_re [MEM_LAT];
    bit [29:0]   hist_wa [MEM_LAT];
    logic [31:0] wr_word;

    function automatic logic [31:0] word_rd(input bit [29:0] wa);
        return mem_w.exists(wa) ? mem_w[wa] : 32'h0;
    endfunction

    always @(posedge clk) begin
        for (int i = MEM_LAT - 1; i > 0; i--) begin
            hist_re[i] = hist_re[i-1];
            hist_wa[i] = hist_wa[i-1];
        end
        hist_re[0] = mem_re;
        hist_wa[0] = mem_addr[31:2];
        if (mem_we) begin
            wr_word = word_rd(mem_addr[31:2]);
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) wr_word[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_w[mem_addr[31:2]] = wr_word;
        end
    end

    always @(negedge clk)
        mem_rdata = hist_re[MEM_LAT-1] ? word_rd(hist_wa[MEM_LAT-1]) : $urandom;

    // Reference: a plain byte-addressed memory updated by the bench itself.
    logic [7:0] ref_mem [bit [31:0]];

    function automatic logic [7:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++)
            if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},    {31'd0, req_ready},    32'd1);
        check({tag, "_stall"},        {31'd0, stall},        32'd0);
        check({tag, "_resp_valid"},   {31'd0, resp_valid},   32'd0);
        check({tag, "_misalign_err"}, {31'd0, misalign_err}, 32'd0);
        check({tag, "_mem_re_we"},    {30'd0, mem_re, mem_we}, 32'd0);
        check({tag, "_mem_be"},       {28'd0, mem_be},       32'd0);
        check({tag, "_mem_addr"},     mem_addr,              32'd0);
        check({tag, "_mem_wdata"},    mem_wdata,             32'd0);
        check({tag, "_resp_rdata"},   resp_rdata,            32'd0);
    endtask

    task automatic access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata, output logic [31:0] got);
        int          n, ready_t, resp_t, resp_cnt, err_cnt, beats;
        int          exp_beats, exp_ready, exp_resp;
        bit          split, err;
        logic [31:0] a0, a1, ba, exp_data, exp_lanes, word;
        logic [3:0]  be0, be1, exp_be;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        split = (int'(addr[1:0]) + n) > 4;
        err   = split && !SPLIT_EN;
        a0 = {addr[31:2], 2'b00};
        a1 = a0 + 32'd4;
        be0 = 4'd0; be1 = 4'd0; exp_data = 32'd0; exp_lanes = 32'd0;
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            if (ba[31:2] == addr[31:2]) be0[ba[1:0]] = 1'b1;
            else                        be1[ba[1:0]] = 1'b1;
            exp_data[8*i +: 8] = ref_rd(ba);
            exp_lanes[8*int'(ba[1:0]) +: 8] = wdata[8*i +: 8];
        end
        if (n == 1 && !uns) exp_data = {{24{exp_data[7]}}, exp_data[7:0]};
        if (n == 2 && !uns) exp_data = {{16{exp_data[15]}}, exp_data[15:0]};
        exp_beats = err ? 0 : (split ? 2 : 1);
        exp_ready = err ? 2 : (split ? 3 : 2) + (we ? 0 : MEM_LAT + 1);
        exp_resp  = (!we && !err) ? 1 : 0;

        got = 32'd0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clk);
        ready_t = 0; resp_t = 0; resp_cnt = 0; err_cnt = 0; beats = 0;
        for (int t = 1; t <= 40 && ready_t == 0; t++) begin
            @(negedge clk);
            if (t == 1) begin
                req_valid = 1'b0;
                check("ready_low_t1", {31'd0, req_ready}, 32'd0);
            end
            check("stall_vs_ready", {31'd0, stall}, {31'd0, !req_ready});
            if (t <= 2) begin
                exp_be = err ? 4'd0 : (t == 1) ? be0 : (split ? be1 : 4'd0);
                check($sformatf("be_t%0d", t), {28'd0, mem_be}, {28'd0, exp_be});
                if (exp_be != 4'd0) begin
                    check($sformatf("addr_t%0d", t), mem_addr, (t == 1) ? a0 : a1);
                    check($sformatf("re_we_t%0d", t), {30'd0, mem_re, mem_we}, {30'd0, !we, we});
                    if (we)
                        check($sformatf("wdata_t%0d", t), mem_wdata & lane_mask(exp_be),
                              exp_lanes & lane_mask(exp_be));
                end
            end
            if (mem_re || mem_we) beats++;
            if (resp_valid) begin
                resp_cnt++;
                resp_t = t;
                got = resp_rdata;
            end
            if (misalign_err) begin
                err_cnt++;
                check("misalign_t", t, 1);
            end
            if (req_ready) ready_t = t;
        end
        check("ready_latency", ready_t, exp_ready);
        check("beat_count", beats, exp_beats);
        check("resp_count", resp_cnt, exp_resp);
        check("misalign_count", err_cnt, {31'd0, err});
        if (exp_resp == 1) begin
            check("resp_latency", resp_t, exp_ready - 1);
            check("resp_data", got, exp_data);
        end
        if (we && !err)
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            word = word_rd(ba[31:2]);
            check("mem_byte", {24'd0, word[8*int'(ba[1:0]) +: 8]}, {24'd0, ref_rd(ba)});
        end
    endtask

    task automatic reset_mid_load(input logic [31:0] addr);
        int bad;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (MEM_LAT + 6) begin
            @(negedge clk);
            if (resp_valid || !req_ready || stall) bad++;
        end
        check("rst_quiet_after", bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got, r_addr, r_wdata;
        logic [1:0]  r_size;
        bit          r_we, r_uns;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_size = 2'd0; req_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst_init");
        rst_n = 1'b1;

        access(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, got);
        access(1'b0, 32'h100, 2'd2, 1'b0, 32'd0, got);
        check("lw_0x100", got, 32'hDEADBEEF);
        access(1'b1, 32'h100, 2'd2, 1'b0, 32'h80112233, got);
        access(1'b0, 32'h103, 2'd0, 1'b0, 32'd0, got);
        check("lb_0x103", got, 32'hFFFFFF80);
        access(1'b0, 32'h103, 2'd0, 1'b1, 32'd0, got);
        check("lbu_0x103", got, 32'h00000080);
        access(1'b1, 32'h100, 2'd2, 1'b0, 32'h44332211, got);
        access(1'b1, 32'h104, 2'd2, 1'b0, 32'h88776655, got);
        access(1'b0, 32'h102, 2'd2, 1'b0, 32'd0, got);
`ifdef DMEM_SPLIT_EN
        check("lw_0x102", got, 32'h66554433);
`endif
        access(1'b1, 32'h107, 2'd1, 1'b0, 32'h0000ABCD, got);
        access(1'b1, 32'hFFFFFFFC, 2'd2, 1'b0, 32'hCAFEF00D, got);
        access(1'b1, 32'h00000000, 2'd2, 1'b0, 32'h01234567, got);
        access(1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'd0, got);
`ifdef DMEM_SPLIT_EN
        check("lw_wrap", got, 32'h4567CAFE);
`endif

        for (int i = 0; i < 300; i++) begin
            r_we    = ($urandom_range(0, 2) == 0);
            r_size  = 2'($urandom_range(0, 3));
            r_uns   = 1'($urandom_range(0, 1));
            r_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) r_addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 15));
            else                           r_addr = 32'h100 + 32'($urandom_range(0, 63));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            access(r_we, r_addr, r_size, r_uns, r_wdata, got);
        end

        reset_mid_load(SPLIT_EN ? 32'h102 : 32'h100);
        access(1'b0, 32'h104, 2'd2, 1'b0, 32'd0, got);
        access(1'b0, 32'h106, 2'd1, 1'b1, 32'd0, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
